// File: rtl/channel_dispatcher_if.sv
// Upstream payload and per-channel downstream signals of the channel dispatcher.
// The slave modport is the dispatcher; the master modport is its environment.
interface channel_dispatcher_if #(
    parameter int WIDTH               = 10,
    parameter int LATENCY_COUNT_WIDTH = 10,
    parameter int N_OUT               = 4
);
    logic [WIDTH-1:0]                     in_data;
    logic                                 in_valid;
    logic                                 in_ready;
    logic [LATENCY_COUNT_WIDTH-1:0]       in_latency;
    logic [N_OUT*WIDTH-1:0]               out_data;
    logic [N_OUT-1:0]                     out_valid;
    logic [N_OUT-1:0]                     out_ready;
    logic [N_OUT*LATENCY_COUNT_WIDTH-1:0] out_latency;
    logic [31:0]                          dispatch_count;

    modport slave (
        input  in_data, in_valid, out_ready, out_latency,
        output in_ready, in_latency, out_data, out_valid, dispatch_count
    );

    modport master (
        output in_data, in_valid, out_ready, out_latency,
        input  in_ready, in_latency, out_data, out_valid, dispatch_count
    );
endinterface

// File: rtl/channel_dispatcher.sv
// Single-entry dispatcher: routes each held payload to the ready channel with the
// lowest reported latency, breaking ties round-robin from rr_ptr.
module channel_dispatcher #(
    parameter int WIDTH               = 10,
    parameter int LATENCY_COUNT_WIDTH = 10,
    parameter int N_OUT               = 4,
    parameter int IDX_WIDTH           = $clog2(N_OUT)
) (
    input  logic                 clk,
    input  logic                 rst,
    channel_dispatcher_if.slave  bus
);
    localparam int LW = LATENCY_COUNT_WIDTH;

    logic                 hold_valid;
    logic [WIDTH-1:0]     hold_data;
    logic [IDX_WIDTH-1:0] rr_ptr;
    logic [IDX_WIDTH-1:0] sel;
    logic [IDX_WIDTH-1:0] rr_next;
    logic                 any_elig;
    logic                 fire;
    logic                 accept;
    logic [LW-1:0]        lat [N_OUT];
    logic [LW-1:0]        best_lat;
    logic [LW-1:0]        min_lat;
    logic [LW+1:0]        lat_sum;
    logic [LW-1:0]        lat_sat;
    logic [LW-1:0]        in_latency_q;
    logic [31:0]          count_q;

    always_comb begin
        for (int k = 0; k < N_OUT; k++) lat[k] = bus.out_latency[k*LW +: LW];
    end

    // Circular scan from rr_ptr; strict '<' keeps the first tied channel.
    // Latencies of non-ready channels are never compared, so X there cannot leak.
    always_comb begin
        logic [IDX_WIDTH:0]   sum;
        logic [IDX_WIDTH-1:0] idx;
        sel      = '0;
        best_lat = '1;
        any_elig = 1'b0;
        sum      = '0;
        idx      = '0;
        for (int i = 0; i < N_OUT; i++) begin
            sum = {1'b0, rr_ptr} + (IDX_WIDTH+1)'(i);
            if (sum >= (IDX_WIDTH+1)'(N_OUT)) sum = sum - (IDX_WIDTH+1)'(N_OUT);
            idx = sum[IDX_WIDTH-1:0];
            if (bus.out_ready[idx]) begin
                if (!any_elig || (lat[idx] < best_lat)) begin
                    any_elig = 1'b1;
                    best_lat = lat[idx];
                    sel      = idx;
                end
            end
        end
    end

    // Upstream estimate looks at every channel, ready or not.
    always_comb begin
        min_lat = lat[0];
        for (int k = 1; k < N_OUT; k++) begin
            if (lat[k] < min_lat) min_lat = lat[k];
        end
        lat_sum = {2'b00, min_lat} + (LW+2)'(1) + (LW+2)'(hold_valid);
        lat_sat = (lat_sum > {2'b00, {LW{1'b1}}}) ? {LW{1'b1}} : lat_sum[LW-1:0];
    end

    assign fire    = hold_valid & any_elig & ~rst;
    assign accept  = bus.in_valid & bus.in_ready;
    assign rr_next = (sel == IDX_WIDTH'(N_OUT-1)) ? '0 : sel + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid   <= 1'b0;
            hold_data    <= '0;
            rr_ptr       <= '0;
            count_q      <= '0;
            in_latency_q <= LW'(1);
        end else begin
            if (accept) begin
                hold_valid <= 1'b1;
                hold_data  <= bus.in_data;
            end else if (fire) begin
                hold_valid <= 1'b0;
            end
            if (fire) begin
                rr_ptr  <= rr_next;
                count_q <= count_q + 32'd1;
            end
            in_latency_q <= lat_sat;
        end
    end

    assign bus.in_ready       = ~hold_valid | fire;
    assign bus.out_valid      = fire ? (N_OUT'(1) << sel) : '0;
    assign bus.out_data       = {N_OUT{hold_data}};
    assign bus.in_latency     = in_latency_q;
    assign bus.dispatch_count = count_q;
endmodule

// File: tb/tb_channel_dispatcher.sv
// Randomized and directed checks of channel_dispatcher against a transaction-level model.
module tb_channel_dispatcher;
    localparam int N  = 4;
    localparam int W  = 10;
    localparam int LW = 10;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    channel_dispatcher_if #(.WIDTH(W), .LATENCY_COUNT_WIDTH(LW), .N_OUT(N)) bus ();
    channel_dispatcher #(.WIDTH(W), .LATENCY_COUNT_WIDTH(LW), .N_OUT(N)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    channel_dispatcher_if #(.WIDTH(W), .LATENCY_COUNT_WIDTH(4), .N_OUT(N)) sbus ();
    channel_dispatcher #(.WIDTH(W), .LATENCY_COUNT_WIDTH(4), .N_OUT(N)) u_sat (
        .clk(clk), .rst(rst), .bus(sbus)
    );

    int n_chk = 0;
    int n_err = 0;
    int olat [N];

    // Reference state: what the dispatcher holds and has done, not how.
    bit          m_hold;
    int          m_data;
    int          m_rr;
    int unsigned m_cnt;
    int          m_lat;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic set_lat(input int a, input int b, input int c, input int d);
        olat[0] = a; olat[1] = b; olat[2] = c; olat[3] = d;
        for (int k = 0; k < N; k++) bus.out_latency[k*LW +: LW] = olat[k][LW-1:0];
    endtask

    // Lowest latency among ready channels; ties go to the one fewest steps past rr.
    function automatic int pick();
        int best = -1;
        for (int k = 0; k < N; k++) begin
            if (bus.out_ready[k]) begin
                if (best < 0 || olat[k] < olat[best] ||
                    (olat[k] == olat[best] && ((k - m_rr + N) % N) < ((best - m_rr + N) % N)))
                    best = k;
            end
        end
        return best;
    endfunction

    task automatic cycle();
        int s;
        bit f;
        int mn;
        @(negedge clk);
        s = pick();
        f = m_hold && (s >= 0) && !rst;
        chk("in_ready", bus.in_ready, !m_hold || f);
        chk("out_valid", bus.out_valid, f ? (64'd1 << s) : 64'd0);
        if (f) chk("out_data", bus.out_data[s*W +: W], m_data);
        chk("in_latency", bus.in_latency, m_lat);
        chk("dispatch_count", bus.dispatch_count, m_cnt);
        @(posedge clk);
        if (rst) begin
            m_hold = 0; m_rr = 0; m_cnt = 0; m_lat = 1;
        end else begin
            mn = olat[0];
            for (int k = 1; k < N; k++) if (olat[k] < mn) mn = olat[k];
            m_lat = mn + 1 + int'(m_hold);
            if (m_lat > (1 << LW) - 1) m_lat = (1 << LW) - 1;
            if (f) begin
                m_cnt++;
                m_rr = (s + 1) % N;
            end
            if (bus.in_valid && (!m_hold || f)) begin
                m_hold = 1;
                m_data = int'(bus.in_data);
            end else if (f) begin
                m_hold = 0;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = '0;
        set_lat(0, 0, 0, 0);
        sbus.in_valid = 1'b0; sbus.in_data = '0; sbus.out_ready = '1; sbus.out_latency = '0;
        m_hold = 0; m_data = 0; m_rr = 0; m_cnt = 0; m_lat = 1;
        @(posedge clk); #1;
        rst = 1'b0;

        // Reset state
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_latency", bus.in_latency, 1);
        chk("rst_count", bus.dispatch_count, 0);

        // Latency pick with a tie, then tie resolved from the advanced pointer
        bus.out_ready = 4'hF;
        set_lat(7, 3, 9, 3);
        bus.in_valid = 1'b1; bus.in_data = 10'h155;
        cycle();
        bus.in_data = 10'h0AB;
        #1 chk("first_sel", bus.out_valid, 4'b0010);
        chk("first_data", bus.out_data[1*W +: W], 10'h155);
        cycle();
        bus.in_valid = 1'b0;
        #1 chk("second_sel", bus.out_valid, 4'b1000);
        chk("count_after_first", bus.dispatch_count, 1);
        cycle();
        chk("count_after_second", bus.dispatch_count, 2);

        // Stall with nothing ready, then release channel 0
        bus.out_ready = 4'h0;
        bus.in_valid = 1'b1; bus.in_data = 10'h0AA;
        cycle();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("stall_in_ready", bus.in_ready, 0);
            chk("stall_out_valid", bus.out_valid, 0);
            chk("stall_data", bus.out_data[0 +: W], 10'h0AA);
        end
        bus.out_ready = 4'b0001;
        #1 chk("release_ch0", bus.out_valid, 4'b0001);
        cycle();

        // 100 back-to-back payloads
        do_reset();
        bus.out_ready = 4'hF;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            set_lat($urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5));
            bus.in_data = W'($urandom);
            cycle();
        end
        bus.in_valid = 1'b0;
        cycle();
        chk("burst_count", bus.dispatch_count, 100);

        // Reset while holding a payload
        bus.out_ready = 4'h0;
        bus.in_valid = 1'b1; bus.in_data = 10'h3FF;
        cycle();
        bus.in_valid = 1'b0;
        bus.out_ready = 4'hF;
        rst = 1'b1;
        #1 chk("rst_no_pulse", bus.out_valid, 0);
        cycle();
        rst = 1'b0;
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_in_ready", bus.in_ready, 1);
        chk("midrst_in_latency", bus.in_latency, 1);
        chk("midrst_count", bus.dispatch_count, 0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_data   = W'($urandom);
            bus.out_ready = N'($urandom);
            if ($urandom_range(0, 7) == 0)
                set_lat($urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 1023), 1023);
            else
                set_lat($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
            rst = ($urandom_range(0, 63) == 0);
            cycle();
        end
        rst = 1'b0;

        // Saturation on the 4-bit latency instance
        sbus.out_latency = 16'hFFFF;
        sbus.out_ready = 4'h0;
        sbus.in_valid = 1'b1; sbus.in_data = 10'h005;
        @(posedge clk); #1;
        sbus.in_valid = 1'b0;
        @(posedge clk); #1;
        chk("sat_in_latency", sbus.in_latency, 15);
        chk("sat_hold", sbus.in_ready, 0);
        sbus.out_latency = 16'h2222;
        sbus.out_ready = 4'hF;
        @(posedge clk); #1;
        chk("sat_hold_lat", sbus.in_latency, 4);
        @(posedge clk); #1;
        chk("sat_idle_lat", sbus.in_latency, 3);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/channel_dispatcher.md
CHANNEL_DISPATCHER -- requirements
Module: channel_dispatcher

Interface
REQ-001 SHALL have parameter WIDTH, default 10, meaning payload width in bits.
REQ-002 SHALL have parameter LATENCY_COUNT_WIDTH, default 10, meaning latency estimate width in bits.
REQ-003 SHALL have parameter N_OUT, default 4, meaning number of downstream channels (range 2..16).
REQ-004 SHALL have parameter IDX_WIDTH, default $clog2(N_OUT), meaning width of the channel index.
REQ-005 SHALL have port clk  input  1  clock; single clock domain, all state updates on posedge.
REQ-006 SHALL have port rst  input  1  synchronous active-high reset.
REQ-007 SHALL have port in_data  input  WIDTH  upstream payload.
REQ-008 SHALL have port in_valid  input  1  upstream payload valid.
REQ-009 SHALL have port in_ready  output  1  dispatcher can accept a payload this cycle.
REQ-010 SHALL have port in_latency  output  LATENCY_COUNT_WIDTH  estimated wait in cycles reported upstream.
REQ-011 SHALL have port out_data  output  N_OUT*WIDTH  per-channel payload; slice k goes to channel k.
REQ-012 SHALL have port out_valid  output  N_OUT  per-channel valid.
REQ-013 SHALL have port out_ready  input  N_OUT  per-channel ready, meaning channel FIFO not full.
REQ-014 SHALL have port out_latency  input  N_OUT*LATENCY_COUNT_WIDTH  per-channel latency estimate; slice k comes from channel k.
REQ-015 SHALL have port dispatch_count  output  32  total payloads dispatched; wraps modulo 2^32.

Function
REQ-016 SHALL hold one payload in a single-entry holding register (hold_valid, hold_data).
REQ-017 SHALL define eligible[k] = out_ready[k].
REQ-018 SHALL define fire = hold_valid AND (eligible != 0).
REQ-019 SHALL select channel sel: among eligible channels, the one with the smallest unsigned out_latency.
REQ-020 SHALL break latency ties by choosing the first tied index found scanning circularly from rr_ptr upward.
REQ-021 SHALL drive out_valid[k] = 1 only for k == sel, and only when fire; all other bits SHALL be 0.
REQ-022 SHALL drive every out_data slice with hold_data; downstream SHALL qualify it with out_valid.
REQ-023 SHALL drive in_ready = NOT hold_valid OR fire (combinational pass-through of downstream ready).
REQ-024 SHALL, on a cycle with in_valid AND in_ready, load in_data into hold_data and set hold_valid = 1 on the next cycle.
REQ-025 SHALL, on a cycle with fire and no accept, clear hold_valid on the next cycle.
REQ-026 SHALL, on a cycle with fire and accept together, keep hold_valid = 1 and load the new payload (back-to-back throughput of 1/cycle).
REQ-027 SHALL, with hold_valid = 1 and no eligible channel, stall: hold_data unchanged, in_ready = 0, out_valid = 0.
REQ-028 SHALL give a payload minimum latency of 1 cycle from in_valid & in_ready to out_valid.
REQ-029 SHALL update rr_ptr on fire to (sel + 1) mod N_OUT, and leave it unchanged otherwise.
REQ-030 SHALL register in_latency each cycle as min over all k of out_latency[k] (ready or not), plus 1, plus hold_valid.
REQ-031 SHALL saturate in_latency at all-ones and never wrap.
REQ-032 SHALL increment dispatch_count by 1 on every fire.
REQ-033 SHALL keep in_data, out_latency and out_ready combinational paths free of latches; X on an out_latency slice whose out_ready = 0 SHALL NOT affect sel.

Reset
REQ-034 SHALL, on rst = 1 at posedge clk, set hold_valid = 0, rr_ptr = 0, dispatch_count = 0 and in_latency = 1.
REQ-035 SHALL drive out_valid = 0 and in_ready = 1 in the cycle after reset.
REQ-036 SHALL discard a held payload when reset is asserted mid-operation, with no out_valid pulse for it.
REQ-037 SHALL give rst priority over simultaneous accept or fire.

Verification
REQ-038 SHALL cover: N_OUT=4, all ready, out_latency = {7,3,9,3} (ch0..3), rr_ptr = 0, one payload 0x155 -> out_valid = 0b0010 one cycle after accept; rr_ptr becomes 2; dispatch_count = 1.
REQ-039 SHALL cover: same latencies, second payload immediately following -> goes to ch3 (tie resolved from rr_ptr = 2), out_valid = 0b1000.
REQ-040 SHALL cover: all out_ready = 0 while holding 0x0AA for 5 cycles -> in_ready = 0, out_valid = 0 throughout, hold_data stable; raising out_ready[0] -> ch0 fires in that cycle.
REQ-041 SHALL cover: continuous in_valid for 100 cycles, all ready -> 100 dispatches, no bubbles after the first, dispatch_count = 100.
REQ-042 SHALL cover: LATENCY_COUNT_WIDTH = 4, all out_latency = 15, hold_valid = 1 -> in_latency = 15 (saturated); with all out_latency = 2 and hold_valid = 0 -> in_latency = 3.
REQ-043 SHALL cover: rst asserted with a payload held -> next cycle hold_valid = 0, out_valid = 0, in_ready = 1, in_latency = 1, dispatch_count = 0.
